// File: rtl/vga_text_writer.sv
// ---------------------------------------------------------------------------
// vga_text_writer
//
// CPU-side writer for the dual-port VGA text memory. The CPU sends character,
// cursor and clear commands over a valid/ready handshake. They are buffered
// in a small command FIFO and turned into writes on the memory write port.
// The VGA side only reads the memory, so this block is the only writer.
//
// Ports
//   input_clk  in   1      CPU clock, all logic on the rising edge
//   rst        in   1      synchronous active-high reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      FIFO can accept a command (not full)
//   cmd_op     in   2      00 PUTC, 01 SETCUR, 10 CLEAR, 11 RAW
//   cmd_data   in   DATAW  PUTC char [7:0]; SETCUR cell; RAW addr [ADDRW+7:8],
//                          char [7:0]
//   mem_we     out  1      registered text memory write strobe
//   mem_addr   out  ADDRW  registered text memory write address
//   mem_wdata  out  DATAW  registered write data, char in [7:0], rest zero
//   cursor     out  ADDRW  current cursor cell index
//   busy       out  1      FIFO non-empty or clear sweep in progress
// ---------------------------------------------------------------------------
module vga_text_writer #(
  parameter int COLS       = 16,
  parameter int ROWS       = 16,
  parameter int ADDRW      = 8,
  parameter int DATAW      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             input_clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DATAW-1:0] cmd_data,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [DATAW-1:0] mem_wdata,
  output logic [ADDRW-1:0] cursor,
  output logic             busy
);

  localparam int CELLS = COLS * ROWS;
  localparam int PTRW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW  = $clog2(FIFO_DEPTH + 1);
  localparam int ENTW  = DATAW + 2;

  localparam logic [ADDRW-1:0] LAST_CELL  = ADDRW'(CELLS - 1);
  localparam logic [CNTW-1:0]  FULL_COUNT = CNTW'(FIFO_DEPTH);
  localparam logic [7:0]       NEWLINE    = 8'h0A;
  localparam logic [7:0]       SPACE      = 8'h20;

  localparam logic [1:0] OP_PUTC   = 2'b00;
  localparam logic [1:0] OP_SETCUR = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ADDRW-1:0] clr_q, clr_d;
  logic [ADDRW-1:0] cursor_q, cursor_d;
  logic             memWe_q, memWe_d;
  logic [ADDRW-1:0] memAddr_q, memAddr_d;
  logic [DATAW-1:0] memWdata_q, memWdata_d;

  logic [ENTW-1:0]  fifoMem [FIFO_DEPTH];
  logic [PTRW-1:0]  rdPtr_q, rdPtr_d;
  logic [PTRW-1:0]  wrPtr_q, wrPtr_d;
  logic [CNTW-1:0]  count_q, count_d;

  logic             push;
  logic             pop;
  logic [ENTW-1:0]  head;
  logic [1:0]       headOp;
  logic [DATAW-1:0] headData;
  logic [31:0]      nextRow;

  assign cmd_ready = (count_q != FULL_COUNT);
  assign busy      = (count_q != '0) || (state_q == CLEAR);
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign cursor    = cursor_q;

  // Popping is frozen while a clear sweep owns the write port.
  assign push     = cmd_valid && cmd_ready;
  assign pop      = (state_q == RUN) && (count_q != '0);
  assign head     = fifoMem[rdPtr_q];
  assign headOp   = head[ENTW-1 -: 2];
  assign headData = head[DATAW-1:0];

  // FIFO storage carries no reset; only the pointers and count define
  // which entries are meaningful.
  always_ff @(posedge input_clk) begin
    if (push) begin
      fifoMem[wrPtr_q] <= {cmd_op, cmd_data};
    end
  end

  // State register for the FSM, FIFO bookkeeping and registered outputs.
  always_ff @(posedge input_clk) begin
    if (rst) begin
      state_q    <= RUN;
      clr_q      <= '0;
      cursor_q   <= '0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      cursor_q   <= cursor_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
    end
  end

  // Next-state logic: FIFO pointer/count updates, command execution in RUN
  // and the one-cell-per-cycle space sweep in CLEAR.
  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    cursor_d   = cursor_q;
    memWe_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    rdPtr_d    = pop  ? rdPtr_q + PTRW'(1) : rdPtr_q;
    wrPtr_d    = push ? wrPtr_q + PTRW'(1) : wrPtr_q;
    count_d    = count_q;
    nextRow    = '0;

    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      RUN: begin
        if (pop) begin
          case (headOp)
            OP_PUTC: begin
              if (headData[7:0] == NEWLINE) begin
                // Start of the following row; past the last row wraps to 0.
                nextRow = (32'(cursor_q) / 32'(COLS) + 32'd1) * 32'(COLS);
                cursor_d = (nextRow >= 32'(CELLS)) ? '0 : nextRow[ADDRW-1:0];
              end else begin
                memWe_d    = 1'b1;
                memAddr_d  = cursor_q;
                memWdata_d = DATAW'(headData[7:0]);
                cursor_d   = (cursor_q == LAST_CELL) ? '0 : cursor_q + ADDRW'(1);
              end
            end
            OP_SETCUR: begin
              // The whole data word is range-checked, so large values that
              // alias into range in the low bits still snap to cell 0.
              cursor_d = (headData < DATAW'(CELLS)) ? headData[ADDRW-1:0] : '0;
            end
            OP_CLEAR: begin
              state_d = CLEAR;
              clr_d   = '0;
            end
            default: begin
              if (32'(headData[ADDRW+7:8]) < 32'(CELLS)) begin
                memWe_d    = 1'b1;
                memAddr_d  = headData[ADDRW+7:8];
                memWdata_d = DATAW'(headData[7:0]);
              end
            end
          endcase
        end
      end
      CLEAR: begin
        memWe_d    = 1'b1;
        memAddr_d  = clr_q;
        memWdata_d = DATAW'(SPACE);
        if (clr_q == LAST_CELL) begin
          state_d  = RUN;
          cursor_d = '0;
          clr_d    = '0;
        end else begin
          clr_d = clr_q + ADDRW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_vga_text_writer.sv
// ---------------------------------------------------------------------------
// tb_vga_text_writer
//
// Directed bench for vga_text_writer. Every memory write seen on the port is
// logged with its cycle number, and each scenario task compares the log and
// the status outputs against values worked out by hand or by a tiny cursor
// model.
// ---------------------------------------------------------------------------
module tb_vga_text_writer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  cursor;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  logic [7:0]  logAddr[$];
  logic [31:0] logData[$];
  int          logCyc[$];

  vga_text_writer dut (
    .input_clk (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cursor    (cursor),
    .busy      (busy)
  );

  // 10 ns clock with a free-running cycle counter for latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Write monitor, sampled on the falling edge well away from updates.
  always @(negedge clk) begin
    if (mem_we) begin
      logAddr.push_back(mem_addr);
      logData.push_back(mem_wdata);
      logCyc.push_back(cycle);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    logAddr.delete();
    logData.delete();
    logCyc.delete();
  endtask

  task automatic doReset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    step();
    step();
    rst = 1'b0;
    clearLog();
  endtask

  // Presents one command and holds it until it has been accepted.
  task automatic sendCmd(input logic [1:0] op, input logic [31:0] data);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    while (!cmd_ready && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) begin
      tests++;
      fails++;
      $display("[TB] FAIL send_timeout: cmd_ready stuck low, got 0 expected 1");
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 2000) begin
      step();
      n++;
    end
    tests++;
    if (n >= 2000) begin
      fails++;
      $display("[TB] FAIL idle_timeout: busy got 1 expected 0");
    end
    step();
    step();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    step();
    step();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", cmd_ready); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("[TB] FAIL reset_we: got %b expected 0", mem_we); end
    tests++; if (mem_addr !== 8'h00) begin fails++; $display("[TB] FAIL reset_addr: got %0h expected 0", mem_addr); end
    tests++; if (mem_wdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_wdata: got %0h expected 0", mem_wdata); end
    tests++; if (cursor !== 8'h00) begin fails++; $display("[TB] FAIL reset_cursor: got %0h expected 0", cursor); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    clearLog();
  endtask

  // 'H','i' back to back: first write 2 cycles after acceptance, then 1/cycle.
  task automatic test_putc();
    doReset();
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 32'h48;
    step();
    cmd_data = 32'h69;
    tests++; if (mem_we !== 1'b0) begin fails++; $display("[TB] FAIL putc_early_we: got %b expected 0", mem_we); end
    step();
    cmd_valid = 1'b0;
    tests++; if (mem_we !== 1'b1 || mem_addr !== 8'd0 || mem_wdata !== 32'h48) begin
      fails++; $display("[TB] FAIL putc_h: got we=%b addr=%0h data=%0h expected we=1 addr=0 data=48", mem_we, mem_addr, mem_wdata);
    end
    step();
    tests++; if (mem_we !== 1'b1 || mem_addr !== 8'd1 || mem_wdata !== 32'h69) begin
      fails++; $display("[TB] FAIL putc_i: got we=%b addr=%0h data=%0h expected we=1 addr=1 data=69", mem_we, mem_addr, mem_wdata);
    end
    step();
    tests++; if (mem_we !== 1'b0 || cursor !== 8'd2) begin
      fails++; $display("[TB] FAIL putc_after: got we=%b cursor=%0d expected we=0 cursor=2", mem_we, cursor);
    end
  endtask

  task automatic test_setcur_wrap();
    doReset();
    sendCmd(2'b01, 32'd255);
    sendCmd(2'b00, 32'h41);
    waitIdle();
    tests++; if (logAddr.size() != 1 || logAddr[0] !== 8'd255 || logData[0] !== 32'h41) begin
      fails++; $display("[TB] FAIL setcur_255_write: got %0d writes expected 1 write of 41 at ff", logAddr.size());
    end
    tests++; if (cursor !== 8'd0) begin fails++; $display("[TB] FAIL cursor_wrap: got %0d expected 0", cursor); end
    sendCmd(2'b01, 32'd7);
    waitIdle();
    tests++; if (cursor !== 8'd7) begin fails++; $display("[TB] FAIL setcur_7: got %0d expected 7", cursor); end
    sendCmd(2'b01, 32'd300);
    waitIdle();
    tests++; if (cursor !== 8'd0) begin fails++; $display("[TB] FAIL setcur_300: got %0d expected 0", cursor); end
  endtask

  task automatic test_newline_raw();
    doReset();
    sendCmd(2'b01, 32'd5);
    sendCmd(2'b00, 32'h0A);
    waitIdle();
    tests++; if (logAddr.size() != 0) begin fails++; $display("[TB] FAIL newline_nowrite: got %0d writes expected 0", logAddr.size()); end
    tests++; if (cursor !== 8'd16) begin fails++; $display("[TB] FAIL newline_5: got %0d expected 16", cursor); end
    sendCmd(2'b01, 32'd250);
    sendCmd(2'b00, 32'h0A);
    waitIdle();
    tests++; if (cursor !== 8'd0) begin fails++; $display("[TB] FAIL newline_250: got %0d expected 0", cursor); end
    sendCmd(2'b01, 32'd9);
    sendCmd(2'b11, 32'h0000_335A);
    waitIdle();
    tests++; if (logAddr.size() != 1 || logAddr[0] !== 8'h33 || logData[0] !== 32'h5A) begin
      fails++; $display("[TB] FAIL raw_write: got %0d writes expected 1 write of 5a at 33", logAddr.size());
    end
    tests++; if (cursor !== 8'd9) begin fails++; $display("[TB] FAIL raw_cursor: got %0d expected 9", cursor); end
  endtask

  task automatic test_clear();
    int n = 0;
    int busyLow = 0;
    int bad = 0;
    doReset();
    sendCmd(2'b01, 32'd9);
    waitIdle();
    clearLog();
    sendCmd(2'b10, 32'd0);
    sendCmd(2'b00, 32'h61);
    sendCmd(2'b00, 32'h62);
    sendCmd(2'b00, 32'h63);
    sendCmd(2'b11, 32'h0000_8064);
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("[TB] FAIL clear_full_ready: got %b expected 0", cmd_ready); end
    while (logAddr.size() < 256 && n < 400) begin
      if (!busy) busyLow++;
      step();
      n++;
    end
    tests++; if (busyLow != 0 || n >= 400) begin
      fails++; $display("[TB] FAIL clear_busy: got %0d idle cycles (loop %0d) expected 0", busyLow, n);
    end
    waitIdle();
    tests++; if (logAddr.size() != 260) begin fails++; $display("[TB] FAIL clear_count: got %0d writes expected 260", logAddr.size()); end
    if (logAddr.size() == 260) begin
      for (int i = 0; i < 256; i++) begin
        if (logAddr[i] !== 8'(i) || logData[i] !== 32'h20) bad++;
        if (i > 0 && logCyc[i] != logCyc[i-1] + 1) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("[TB] FAIL clear_sweep: got %0d bad entries expected 0", bad); end
      tests++; if (logAddr[256] !== 8'd0 || logData[256] !== 32'h61 || logAddr[257] !== 8'd1 || logData[257] !== 32'h62 ||
                   logAddr[258] !== 8'd2 || logData[258] !== 32'h63 || logAddr[259] !== 8'h80 || logData[259] !== 32'h64) begin
        fails++; $display("[TB] FAIL clear_queued: got %0h@%0h %0h@%0h expected 61@0 62@1 (then 63@2 64@80)",
                          logData[256], logAddr[256], logData[257], logAddr[257]);
      end
    end
    tests++; if (cursor !== 8'd3) begin fails++; $display("[TB] FAIL clear_cursor: got %0d expected 3", cursor); end
  endtask

  // FIFO full behind a clear sweep while cmd_valid stays high.
  task automatic test_back_to_back();
    int bad = 0;
    doReset();
    sendCmd(2'b10, 32'd0);
    for (int k = 0; k < 4; k++) sendCmd(2'b11, {16'h0, 8'(8'h10 + k), 8'(8'h61 + k)});
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = {16'h0, 8'h14, 8'h65};
    step();
    step();
    tests++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("[TB] FAIL stall_ready: got ready=%b busy=%b expected ready=0 busy=1", cmd_ready, busy);
    end
    cmd_valid = 1'b0;
    sendCmd(2'b11, {16'h0, 8'h14, 8'h65});
    sendCmd(2'b11, {16'h0, 8'h15, 8'h66});
    waitIdle();
    tests++; if (logAddr.size() != 262) begin fails++; $display("[TB] FAIL stall_count: got %0d writes expected 262", logAddr.size()); end
    if (logAddr.size() == 262) begin
      for (int k = 0; k < 6; k++) begin
        if (logAddr[256+k] !== 8'(8'h10 + k) || logData[256+k] !== 32'(8'h61 + k)) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("[TB] FAIL stall_order: got %0d bad entries expected 0", bad); end
    end
  endtask

  // Random gaps and a mix of PUTC/RAW/SETCUR against a cursor model.
  task automatic test_random();
    logic [7:0]  modelCur;
    logic [7:0]  expAddr[$];
    logic [31:0] expData[$];
    logic [7:0]  ch;
    logic [7:0]  ad;
    int          v;
    int          kind;
    int          bad = 0;
    doReset();
    modelCur = 8'd0;
    for (int k = 0; k < 30; k++) begin
      kind = $urandom_range(0, 4);
      if (kind <= 1) begin
        ch = ($urandom_range(0, 4) == 0) ? 8'h0A : 8'(8'h41 + $urandom_range(0, 25));
        sendCmd(2'b00, 32'(ch));
        if (ch == 8'h0A) begin
          modelCur = (modelCur >= 8'd240) ? 8'd0 : ((modelCur & 8'hF0) + 8'd16);
        end else begin
          expAddr.push_back(modelCur);
          expData.push_back(32'(ch));
          modelCur = modelCur + 8'd1;
        end
      end else if (kind <= 3) begin
        ad = 8'($urandom_range(0, 255));
        ch = 8'(8'h30 + $urandom_range(0, 9));
        sendCmd(2'b11, {16'h0, ad, ch});
        expAddr.push_back(ad);
        expData.push_back(32'(ch));
      end else begin
        v = $urandom_range(0, 299);
        sendCmd(2'b01, 32'(v));
        modelCur = (v < 256) ? 8'(v) : 8'd0;
      end
      repeat ($urandom_range(0, 2)) step();
    end
    waitIdle();
    tests++; if (logAddr.size() != expAddr.size()) begin
      fails++; $display("[TB] FAIL random_count: got %0d writes expected %0d", logAddr.size(), expAddr.size());
    end else begin
      for (int i = 0; i < expAddr.size(); i++) begin
        if (logAddr[i] !== expAddr[i] || logData[i] !== expData[i]) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("[TB] FAIL random_writes: got %0d bad entries expected 0", bad); end
    end
    tests++; if (cursor !== modelCur) begin fails++; $display("[TB] FAIL random_cursor: got %0d expected %0d", cursor, modelCur); end
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    doReset();
    sendCmd(2'b01, 32'd40);
    sendCmd(2'b10, 32'd0);
    sendCmd(2'b00, 32'h78);
    while (!(mem_we === 1'b1 && mem_addr === 8'd100) && n < 400) begin
      step();
      n++;
    end
    tests++; if (n >= 400) begin fails++; $display("[TB] FAIL sweep_100_timeout: got no write at 100 expected one"); end
    rst = 1'b1;
    step();
    tests++; if (mem_we !== 1'b0 || cursor !== 8'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL midclear_reset: got we=%b cur=%0d busy=%b ready=%b expected 0 0 0 1", mem_we, cursor, busy, cmd_ready);
    end
    rst = 1'b0;
    clearLog();
    repeat (5) step();
    tests++; if (logAddr.size() != 0 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL midclear_flush: got %0d writes busy=%b expected 0 writes busy=0", logAddr.size(), busy);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    test_reset();
    test_putc();
    test_setcur_wrap();
    test_newline_raw();
    test_clear();
    test_back_to_back();
    test_random();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
